// File: rtl/col_parity_checker_if.sv
// Bus bundle between the column-parity checker (master) and its memory/controller side (slave).
// Carries err_mask only when COLPAR_ERR_MASK_EN is defined.
interface col_parity_checker_if #(
    parameter int W  = 64,
    parameter int AW = 8,
    parameter int CW = 3
`ifdef COLPAR_ERR_MASK_EN
    ,
    parameter int COLS = 5
`endif
);
    logic          start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          err;
    logic [CW:0]   err_cnt;
    logic          done;
`ifdef COLPAR_ERR_MASK_EN
    logic [COLS-1:0] err_mask;
`endif

    modport master (
`ifdef COLPAR_ERR_MASK_EN
        output err_mask,
`endif
        input  start,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data,
        output busy,
        output err,
        output err_cnt,
        output done
    );

    modport slave (
`ifdef COLPAR_ERR_MASK_EN
        input  err_mask,
`endif
        output start,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  busy,
        input  err,
        input  err_cnt,
        input  done
    );
endinterface

// File: rtl/col_parity_checker.sv
// Column-parity checker: re-reads a ROWSxCOLS matrix plus its parity row and writes per-column syndromes.
// Optional COLPAR_ERR_MASK_EN adds a per-column error mask output.
module col_parity_checker #(
    parameter int W    = 64,
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int AW   = 8,
    parameter int CW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    col_parity_checker_if.master bus_io
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int RW = (ROWS > 0) ? $clog2(ROWS + 1) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [AW-1:0] COLS_A   = AW'(COLS);
    localparam logic [AW-1:0] PAR_BASE = AW'(ROWS * COLS);

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          err_q, err_d;
    logic [CW:0]   cnt_q, cnt_d;
    logic          done_q;
`ifdef COLPAR_ERR_MASK_EN
    logic [COLS-1:0] mask_q, mask_d;
`endif

    logic          in_issue, in_write, syn_nz;
    logic [AW-1:0] row_a, col_a, addr_calc;

    assign in_issue = (state_q == S_ISSUE);
    assign in_write = (state_q == S_WRITE);
    assign syn_nz   = (acc_q != '0);

    // Data rows live at row*COLS+col; the parity row follows them at ROWS*COLS+col.
    assign row_a     = AW'(row_q);
    assign col_a     = AW'(col_q);
    assign addr_calc = (row_q < ROW_LAST) ? (row_a * COLS_A) + col_a : PAR_BASE + col_a;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        acc_d   = acc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef COLPAR_ERR_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus_io.start) begin
                    row_d   = '0;
                    col_d   = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
`ifdef COLPAR_ERR_MASK_EN
                    mask_d  = '0;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_LATCH;
            S_LATCH: begin
                acc_d = acc_q ^ bus_io.rd_data;
                if (row_q == ROW_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_WRITE: begin
                if (syn_nz) begin
                    err_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
`ifdef COLPAR_ERR_MASK_EN
                    mask_d = mask_q | (COLS'(1) << col_q);
`endif
                end
                if (col_q == COL_LAST) begin
                    state_d = S_FIN;
                end else begin
                    col_d   = col_q + 1'b1;
                    row_d   = '0;
                    acc_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == S_FIN);
        end
    end

`ifdef COLPAR_ERR_MASK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_q <= '0;
        else     mask_q <= mask_d;
    end
    assign bus_io.err_mask = mask_q;
`endif

    // Strobes come from state alone; addresses and data are zero whenever their strobe is low.
    assign bus_io.rd_en   = in_issue;
    assign bus_io.rd_addr = in_issue ? addr_calc : '0;
    assign bus_io.wr_en   = in_write;
    assign bus_io.wr_addr = in_write ? col_q : '0;
    assign bus_io.wr_data = in_write ? acc_q : '0;
    assign bus_io.busy    = (state_q != S_IDLE);
    assign bus_io.err     = err_q;
    assign bus_io.err_cnt = cnt_q;
    assign bus_io.done    = done_q;
endmodule
